// File: rtl/square_period_detector_pkg.sv
// Shared definitions for square-wave analysis blocks: FSM state encodings and helpers.
package square_period_detector_pkg;

    // Detector phase: no phase reference yet, or measuring half-periods.
    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } state_e;

    // All-ones value of a counter of the given width (width must be below 32).
    function automatic logic [31:0] sat_max(input int unsigned width);
        return (32'h1 << width) - 32'h1;
    endfunction

    // Unsigned distance between two values, larger minus smaller, so it never wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/square_period_detector_edge_sync.sv
// Two-flop level capture of a 1-bit threshold decision with edge and polarity outputs.
module square_period_detector_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic edge_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;

    // Capture the level, then delay it one more cycle for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= level_i;
            s2_q <= s1_q;
        end
    end

    // Both polarities count as an edge.
    assign edge_o  = s1_q ^ s2_q;
    assign level_o = s1_q;

endmodule

// File: rtl/square_period_detector.sv
// Measures half-periods of a square-wave sample stream, tracks stability and flags tone loss.
module square_period_detector
    import square_period_detector_pkg::*;
#(
    parameter int unsigned ResolutionBits = 8,
    parameter int unsigned CounterWidth   = 8,
    parameter int unsigned LockCount      = 3,
    parameter int unsigned Tolerance      = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ResolutionBits-1:0] sample_in_i,
    output logic [CounterWidth-1:0]   freq_out_o,
    output logic                      freq_valid_o,
    output logic                      locked_o,
    output logic                      timeout_o
);

    localparam logic [CounterWidth-1:0] CntMax  = CounterWidth'(sat_max(CounterWidth));
    localparam logic [3:0]              LockCnt = 4'(LockCount);

    state_e                  state_q;
    logic [CounterWidth-1:0] cnt_q;
    logic [CounterWidth-1:0] cnt_d;
    logic [CounterWidth-1:0] prev_q;
    logic                    have_prev_q;
    logic [3:0]              match_cnt_q;
    logic [3:0]              match_cnt_d;
    logic [CounterWidth-1:0] freq_q;
    logic                    valid_q;
    logic                    locked_q;
    logic                    timeout_q;

    logic edge_det;
    logic level;
    logic is_match;
    logic unused_bits;

    square_period_detector_edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (sample_in_i[ResolutionBits-1]),
        .edge_o  (edge_det),
        .level_o (level)
    );

    // Only the MSB drives detection; the rest of the sample and the polarity are unused here.
    assign unused_bits = ^{sample_in_i, level};

    // Saturating counter increment, match test and saturating match-count increment.
    always_comb begin
        cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        is_match    = abs_diff(32'(cnt_q), 32'(prev_q)) <= 32'(Tolerance);
        match_cnt_d = (match_cnt_q >= LockCnt) ? LockCnt : match_cnt_q + 4'd1;
    end

    // Measurement FSM with period counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            match_cnt_q <= 4'd0;
            freq_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= edge_det ? '0 : cnt_d;
            unique case (state_q)
                StIdle: begin
                    // First edge is a phase reference only.
                    if (edge_det) begin
                        state_q     <= StMeasure;
                        have_prev_q <= 1'b0;
                    end
                end
                StMeasure: begin
                    if (edge_det) begin
                        // Edge wins over saturation, so all-ones can be published.
                        freq_q      <= cnt_q;
                        valid_q     <= 1'b1;
                        prev_q      <= cnt_q;
                        have_prev_q <= 1'b1;
                        if (have_prev_q) begin
                            if (is_match) begin
                                match_cnt_q <= match_cnt_d;
                                locked_q    <= (match_cnt_d == LockCnt);
                            end else begin
                                match_cnt_q <= 4'd0;
                                locked_q    <= 1'b0;
                            end
                        end
                    end else if (cnt_q == CntMax) begin
                        state_q     <= StIdle;
                        timeout_q   <= 1'b1;
                        locked_q    <= 1'b0;
                        match_cnt_q <= 4'd0;
                        have_prev_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign freq_out_o   = freq_q;
    assign freq_valid_o = valid_q;
    assign locked_o     = locked_q;
    assign timeout_o    = timeout_q;

endmodule
